// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer states, default sizing, line levels, parity.
package uart_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 8;
   localparam int unsigned PARITY_W       = 32;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Frame sequencer states, common to transmitter and receiver
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } uart_state_e;

   // Even parity bit for a data word (zero-extended to PARITY_W by the caller)
   function automatic logic even_parity(input logic [PARITY_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side receive handshake: byte, status flags and the valid/ack pair.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = DATA_BITS_DEF
);
   logic [DATA_BITS-1:0] d_out;
   logic                 rx_valid;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;
   logic                 rx_ack;

   modport master (
      output d_out,
      output rx_valid,
      output parity_err,
      output frame_err,
      output overrun,
      input  rx_ack
   );

   modport slave (
      input  d_out,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      input  overrun,
      output rx_ack
   );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to RST_VAL.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic clrn,
   input  logic d,
   output logic q
);
   logic meta;

   // Metastability filter: d -> meta -> q
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver: start, LSB-first data, optional even parity, stop.
// Presents each byte with error flags on a valid/ack handshake.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
   parameter bit          PARITY_EN  = 1'b1
) (
   input  logic       clk_uart,
   input  logic       clrn,
   input  logic       rxd,
   uart_rx_if.master  host,
   output logic       receiving
);
   localparam int unsigned CNT_W     = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);
   localparam int unsigned HALF_LAST = OVERSAMPLE / 2 - 1;
   localparam int unsigned OS_LAST   = OVERSAMPLE - 1;
   localparam int unsigned BIT_LAST  = DATA_BITS - 1;

   logic                 rxd_s;

   uart_state_e          state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 perr, perr_nxt;

   logic [DATA_BITS-1:0] d_out_q, d_out_nxt;
   logic                 valid_q, valid_nxt;
   logic                 perr_flag_q, perr_flag_nxt;
   logic                 ferr_q, ferr_nxt;
   logic                 ovr_q, ovr_nxt;
   logic                 receiving_nxt;

   uart_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk  (clk_uart),
      .clrn (clrn),
      .d    (rxd),
      .q    (rxd_s)
   );

   // State, datapath and host-facing registers
   always_ff @(posedge clk_uart or negedge clrn) begin
      if (!clrn) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         perr        <= 1'b0;
         d_out_q     <= '0;
         valid_q     <= 1'b0;
         perr_flag_q <= 1'b0;
         ferr_q      <= 1'b0;
         ovr_q       <= 1'b0;
         receiving   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bit_cnt     <= bit_cnt_nxt;
         shreg       <= shreg_nxt;
         perr        <= perr_nxt;
         d_out_q     <= d_out_nxt;
         valid_q     <= valid_nxt;
         perr_flag_q <= perr_flag_nxt;
         ferr_q      <= ferr_nxt;
         ovr_q       <= ovr_nxt;
         receiving   <= receiving_nxt;
      end
   end

   // Frame sequencing, sampling and handshake next-state logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      bit_cnt_nxt   = bit_cnt;
      shreg_nxt     = shreg;
      perr_nxt      = perr;
      d_out_nxt     = d_out_q;
      valid_nxt     = valid_q;
      perr_flag_nxt = perr_flag_q;
      ferr_nxt      = ferr_q;
      ovr_nxt       = ovr_q;

      // Host consumed the byte; a coinciding frame completion below may reload it
      if (host.rx_ack && valid_q) begin
         valid_nxt = 1'b0;
         ovr_nxt   = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            if (rxd_s == START_BIT) begin
               state_nxt = ST_START;
               cnt_nxt   = '0;
            end
         end

         ST_START: begin
            // Re-check at mid start bit to reject glitches
            if (cnt == CNT_W'(HALF_LAST)) begin
               cnt_nxt     = '0;
               bit_cnt_nxt = '0;
               state_nxt   = (rxd_s == START_BIT) ? ST_DATA : ST_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (cnt == CNT_W'(OS_LAST)) begin
               cnt_nxt   = '0;
               shreg_nxt = DATA_BITS'({rxd_s, shreg} >> 1);
               if (bit_cnt == BIT_W'(BIT_LAST)) begin
                  bit_cnt_nxt = '0;
                  state_nxt   = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + BIT_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_PARITY: begin
            if (cnt == CNT_W'(OS_LAST)) begin
               cnt_nxt   = '0;
               perr_nxt  = rxd_s ^ even_parity(PARITY_W'(shreg));
               state_nxt = ST_STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_STOP: begin
            if (cnt == CNT_W'(OS_LAST)) begin
               cnt_nxt = '0;
               // Unread byte still held: keep it, drop the new frame, flag overrun
               if (valid_q && !host.rx_ack) begin
                  ovr_nxt = 1'b1;
               end else begin
                  d_out_nxt     = shreg;
                  valid_nxt     = 1'b1;
                  perr_flag_nxt = PARITY_EN && perr;
                  ferr_nxt      = (rxd_s != STOP_BIT);
               end
               state_nxt = (rxd_s == STOP_BIT) ? ST_IDLE : ST_WAIT_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         ST_WAIT_IDLE: begin
            // Hold off through a break so a held-low line cannot retrigger
            if (rxd_s == STOP_BIT) begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      receiving_nxt = (state_nxt == ST_START) || (state_nxt == ST_DATA) ||
                      (state_nxt == ST_PARITY) || (state_nxt == ST_STOP);
   end

   assign host.d_out      = d_out_q;
   assign host.rx_valid   = valid_q;
   assign host.parity_err = perr_flag_q;
   assign host.frame_err  = ferr_q;
   assign host.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean/corrupt frames, glitch, overrun, reset, baud skew.
module tb_uart_rx;
   logic clk_uart;
   logic clrn;
   logic rxd;
   logic receiving;

   int n_cmp;
   int n_err;

   uart_rx_if #(.DATA_BITS(8)) host_if ();

   uart_rx #(
      .OVERSAMPLE (16),
      .DATA_BITS  (8),
      .PARITY_EN  (1'b1)
   ) dut (
      .clk_uart  (clk_uart),
      .clrn      (clrn),
      .rxd       (rxd),
      .host      (host_if),
      .receiving (receiving)
   );

   initial clk_uart = 1'b0;
   always #5 clk_uart = ~clk_uart;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Put the next line change just before a clock edge
   task automatic align();
      @(posedge clk_uart);
      #9;
   endtask

   // Start, 8 data bits LSB first, parity bit, stop bit; line left at the stop level
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input int bit_t);
      rxd = 1'b0;
      #(bit_t);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         #(bit_t);
      end
      rxd = par;
      #(bit_t);
      rxd = stop;
      #(bit_t);
   endtask

   task automatic ack();
      @(posedge clk_uart);
      #1;
      host_if.rx_ack = 1'b1;
      @(posedge clk_uart);
      #1;
      host_if.rx_ack = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b;
      int         lat;
      int         bit_t;

      n_cmp = 0;
      n_err = 0;
      clrn  = 1'b0;
      rxd   = 1'b1;
      host_if.rx_ack = 1'b0;

      // Reset state
      #23;
      check_eq("rst_d_out",     32'(host_if.d_out), 0);
      check_eq("rst_rx_valid",  32'(host_if.rx_valid), 0);
      check_eq("rst_flags",     32'({host_if.parity_err, host_if.frame_err, host_if.overrun}), 0);
      check_eq("rst_receiving", 32'(receiving), 0);
      clrn = 1'b1;
      repeat (5) @(posedge clk_uart);

      // Clean 0xA5 frame at exact baud, with latency measurement
      align();
      lat = 0;
      fork
         send_frame(8'hA5, 1'b0, 1'b1, 160);
         begin
            while (!host_if.rx_valid && lat < 300) begin
               @(posedge clk_uart);
               #1;
               lat++;
               if (lat == 80) check_eq("a5_busy", 32'(receiving), 1);
            end
         end
      join
      check_eq("a5_latency", (lat >= 169 && lat <= 171) ? 170 : lat, 170);
      check_eq("a5_d_out",    32'(host_if.d_out), 32'h0000_00A5);
      check_eq("a5_valid",    32'(host_if.rx_valid), 1);
      check_eq("a5_flags",    32'({host_if.parity_err, host_if.frame_err, host_if.overrun}), 0);
      check_eq("a5_idle",     32'(receiving), 0);
      ack();
      check_eq("a5_ack_clr",  32'(host_if.rx_valid), 0);

      // 0x01 with a wrong (zero) parity bit
      align();
      send_frame(8'h01, 1'b0, 1'b1, 160);
      check_eq("p01_d_out",  32'(host_if.d_out), 32'h0000_0001);
      check_eq("p01_perr",   32'(host_if.parity_err), 1);
      check_eq("p01_ferr",   32'(host_if.frame_err), 0);
      ack();

      // 0x3C with a low stop bit, line held low afterwards (break)
      align();
      send_frame(8'h3C, 1'b0, 1'b0, 160);
      #200;
      check_eq("brk_d_out",  32'(host_if.d_out), 32'h0000_003C);
      check_eq("brk_ferr",   32'(host_if.frame_err), 1);
      check_eq("brk_perr",   32'(host_if.parity_err), 0);
      check_eq("brk_valid",  32'(host_if.rx_valid), 1);
      check_eq("brk_wait",   32'(receiving), 0);
      ack();
      #200;
      check_eq("brk_no_retrig", 32'(receiving), 0);
      rxd = 1'b1;
      #400;
      check_eq("brk_no_frame",  32'(host_if.rx_valid), 0);
      check_eq("brk_idle",      32'(receiving), 0);

      // 4-cycle glitch: false start, nothing else changes
      align();
      rxd = 1'b0;
      #40;
      check_eq("gl_start", 32'(receiving), 1);
      rxd = 1'b1;
      #200;
      check_eq("gl_idle",  32'(receiving), 0);
      check_eq("gl_valid", 32'(host_if.rx_valid), 0);
      check_eq("gl_keep",  32'({host_if.d_out, host_if.parity_err, host_if.frame_err, host_if.overrun}),
               32'({8'h3C, 1'b0, 1'b1, 1'b0}));

      // Back-to-back 0x11 / 0x22 without ack: overrun, first byte kept
      align();
      send_frame(8'h11, 1'b0, 1'b1, 160);
      send_frame(8'h22, 1'b0, 1'b1, 160);
      check_eq("ovr_d_out", 32'(host_if.d_out), 32'h0000_0011);
      check_eq("ovr_flag",  32'(host_if.overrun), 1);
      check_eq("ovr_valid", 32'(host_if.rx_valid), 1);
      ack();
      check_eq("ovr_ack",   32'({host_if.rx_valid, host_if.overrun}), 0);

      // Reset in the middle of data bit 4 of 0xFF
      align();
      rxd = 1'b0;
      #160;
      for (int i = 0; i < 4; i++) begin
         rxd = 1'b1;
         #160;
      end
      rxd = 1'b1;
      #80;
      check_eq("mr_busy", 32'(receiving), 1);
      clrn = 1'b0;
      #2;
      check_eq("mr_d_out", 32'(host_if.d_out), 0);
      check_eq("mr_outs",  32'({host_if.rx_valid, host_if.parity_err, host_if.frame_err,
                                host_if.overrun, receiving}), 0);
      #30;
      clrn = 1'b1;
      #400;
      check_eq("mr_no_partial", 32'(host_if.rx_valid), 0);
      align();
      send_frame(8'h5A, 1'b0, 1'b1, 160);
      check_eq("mr_5a_d_out", 32'(host_if.d_out), 32'h0000_005A);
      check_eq("mr_5a_stat",  32'({host_if.rx_valid, host_if.parity_err, host_if.frame_err,
                                   host_if.overrun}), 32'(4'b1000));
      ack();

      // Random bytes with the bit period skewed by about +3% / -3%
      for (int n = 0; n < 256; n++) begin
         b     = 8'($urandom);
         bit_t = (n % 2 == 1) ? 165 : 155;
         align();
         send_frame(b, ^b, 1'b1, bit_t);
         #(2 * bit_t);
         check_eq("lb_d_out", 32'(host_if.d_out), 32'(b));
         check_eq("lb_stat",  32'({host_if.rx_valid, host_if.parity_err, host_if.frame_err,
                                   host_if.overrun}), 32'(4'b1000));
         ack();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
